fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage that owns the PC and feeds the IF/ID pipeline register. It is the writing end of IF/ID: it drives that register's write enable, PC and instruction inputs. It fetches from a variable-latency instruction memory, absorbs ID-stage stalls with a one-entry hold buffer, flushes IF/ID on branch redirects, and freezes on HALT.

## Interface
Parameters:
- WIDTH, 16: PC and instruction width.
- RESET_PC, 16'h0000: PC after reset.
- NOP_INSTR, 16'h0000: bubble encoding (ADD $0,$0,$0).
- HALT_OPCODE, 4'hF: value of instr[15:12] that halts fetch.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- stall_i  in  1  ID hazard; hold IF/ID and PC.
- redirect_i  in  1  taken branch or jump resolved; flush IF/ID.
- redirect_pc_i  in  WIDTH  redirect target.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  WIDTH  fetch address.
- imem_ready_i  in  1  response valid this cycle.
- imem_rdata_i  in  WIDTH  fetched instruction, valid when ready.
- ifid_wen_o  out  1  IF/ID write enable.
- ifid_pc_o  out  WIDTH  PC+2 of the delivered instruction.
- ifid_instr_o  out  WIDTH  delivered instruction or NOP_INSTR.
- halted_o  out  1  fetch frozen on HALT.

## Operation
- States: RUN, KILL, HALTED. Registers: pc, tgt, buf_valid, buf_instr, buf_pc.
- **Memory protocol:**
  - A request is held with a stable address until imem_ready_i is high.
  - Requests are never aborted.
  - imem_ready_i may be high in the request cycle (zero-wait).
- **Request rule:** imem_req_o = (state is RUN or KILL) and !buf_valid. imem_addr_o = pc.
- **IF/ID write:** ifid_wen_o = !stall_i or redirect_i. When no instruction is delivered, the written data is NOP_INSTR, with pc+2 on ifid_pc_o.
- **Delivery source priority (no redirect, no stall):**
  1. Buffer entry, if buf_valid. The buffer clears.
  2. Otherwise, the memory response (ready, state RUN), giving instr = rdata and pc_out = pc+2.
- **Response during stall:** the response is captured into the buffer. pc advances as on delivery.
- **PC advance on an accepted RUN response:**
  - pc <= pc+2.
  - If instr[15:12] == HALT_OPCODE, pc holds and state goes to HALTED. The HALT instruction itself is still delivered or buffered.
- **Redirect (highest priority, overrides stall):**
  - IF/ID is written with NOP_INSTR.
  - The buffer clears.
  - If a request is outstanding and ready is low: tgt <= redirect_pc_i, state <= KILL. pc holds so the address stays stable.
  - Otherwise: pc <= redirect_pc_i, state <= RUN. A same-cycle response is discarded.
  - Redirect exits HALTED, because a HALT may be speculative.
- **KILL:**
  - The response is discarded on ready; then pc <= tgt and state goes to RUN.
  - A redirect arriving in KILL updates tgt.
- **HALTED:** no requests. halted_o = 1. Only rst or redirect_i leaves this state.
- PC arithmetic is modulo 2^WIDTH: pc 16'hFFFE wraps to 16'h0000.

## Timing
- **Values while rst is high:**
  - pc = RESET_PC, state RUN, buf_valid = 0.
  - imem_req_o = 0, ifid_wen_o = 0, halted_o = 0.
  - ifid_pc_o = 0, ifid_instr_o = NOP_INSTR.
- First request at address RESET_PC in the first cycle after rst deasserts.
- **Zero-wait memory:**
  - One instruction per cycle.
  - The instruction appears on ifid_* in the same cycle as its response and is latched by IF/ID at the next edge.
- **Stall:** a buffered response blocks new requests. On stall release, the buffer drains in that cycle and the request reasserts the next cycle, costing one bubble.
- **Redirect:** the first target instruction reaches IF/ID no earlier than one cycle after redirect_i, plus any KILL wait.
- rst mid-KILL or mid-wait: abandon everything. The memory subsystem is reset alongside.

## Structure
- Shared package/include holds NOP_INSTR, HALT_OPCODE, the state encoding and WIDTH defaults, for reuse by the ID decoder and the hazard unit.
- One sub-module, fetch_hold_buf: the one-entry instruction/PC skid register with load, drain and clear.
- The FSM and PC logic stay in fetch_unit.

## Test plan
- **Reset and stream:** rst 2 cycles, zero-wait memory returning addr-based words → addresses 0,2,4,6 on consecutive cycles; ifid_pc_o 2,4,6,8; ifid_wen_o = 1 each cycle.
- **Stall with buffer:** 2-cycle memory latency, stall_i high 3 cycles covering a response at pc 4 → buffer captures it and imem_req_o drops; on release, instr@4 is delivered with ifid_pc_o = 6; the next request is to address 6.
- **Redirect during wait:** request at 8 pending, redirect_i to 16'h0040 → NOP written; address stays 8 until ready; that response is discarded; next request is at 16'h0040.
- **Redirect plus stall:** both high in the same cycle with the buffer full → ifid_wen_o = 1, instr = NOP_INSTR, buffer empty, pc = target.
- **HALT:** memory returns 16'hF000 at pc 10 → it is delivered, then halted_o = 1 and no further requests; a later redirect to 0 resumes fetch at 0 with halted_o = 0.
- **Wrap-around:** RESET_PC = 16'hFFFE → second request at 16'h0000; ifid_pc_o for the first instruction is 16'h0000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and its neighbours (ID decoder,
// hazard unit): datapath width default, bubble encoding, HALT opcode and the
// fetch FSM state encoding.
package fetch_unit_pkg;

    localparam int          WIDTH_DEF       = 16;
    localparam logic [15:0] RESET_PC_DEF    = 16'h0000;
    localparam logic [15:0] NOP_INSTR_DEF   = 16'h0000;  // ADD $0,$0,$0
    localparam logic [3:0]  HALT_OPCODE_DEF = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,  // fetching normally
        ST_KILL   = 2'd1,  // waiting out a request made stale by a redirect
        ST_HALTED = 2'd2   // frozen after fetching a HALT
    } fetch_state_t;

    function automatic logic is_halt(input logic [3:0] opcode,
                                     input logic [3:0] halt_opcode);
        return opcode == halt_opcode;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid register for the fetch stage. Holds an instruction and its
// PC+2 when a memory response arrives while ID is stalled.
//   clk, rst          : clock, synchronous active-high reset
//   load              : capture load_instr/load_pc, entry becomes valid
//   drain             : entry consumed by IF/ID, becomes invalid
//   clear             : entry discarded (redirect), highest priority after rst
//   valid, instr, pc  : current entry
module fetch_hold_buf
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             drain,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_instr,
    input  logic [WIDTH-1:0] load_pc,
    output logic             valid,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] pc
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    // NOTE: the payload has no reset; valid alone qualifies it, so resetting
    // the data would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (load) begin
            instr <= load_instr;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC, issues requests to a variable-latency
// instruction memory and drives the write side of the IF/ID register.
//   clk, rst                 : clock, synchronous active-high reset
//   stall_i                  : ID hazard, hold IF/ID and PC
//   redirect_i/redirect_pc_i : taken branch/jump, flush IF/ID, new PC
//   imem_req_o/imem_addr_o   : fetch request, address stable until ready
//   imem_ready_i/imem_rdata_i: response strobe and instruction
//   ifid_wen_o/pc_o/instr_o  : IF/ID write enable, PC+2, instruction or NOP
//   halted_o                 : fetch frozen after a HALT
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int               WIDTH       = WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(RESET_PC_DEF),
    parameter logic [WIDTH-1:0] NOP_INSTR   = WIDTH'(NOP_INSTR_DEF),
    parameter logic [3:0]       HALT_OPCODE = HALT_OPCODE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic             imem_ready_i,
    input  logic [WIDTH-1:0] imem_rdata_i,
    output logic             ifid_wen_o,
    output logic [WIDTH-1:0] ifid_pc_o,
    output logic [WIDTH-1:0] ifid_instr_o,
    output logic             halted_o
);

    fetch_state_t     state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] pc_plus2;

    logic             buf_valid;
    logic [WIDTH-1:0] buf_instr;
    logic [WIDTH-1:0] buf_pc;
    logic             buf_load;
    logic             buf_drain;

    logic             req;
    logic             resp_run;
    logic             resp_kill;
    logic             outstanding;
    logic             rsp_halt;

    assign pc_plus2 = pc + WIDTH'(2);  // wraps modulo 2^WIDTH

    // A full buffer blocks new requests, so a response can never find the
    // buffer occupied.
    assign req         = !rst && (state != ST_HALTED) && !buf_valid;
    assign resp_run    = req && imem_ready_i && (state == ST_RUN);
    assign resp_kill   = req && imem_ready_i && (state == ST_KILL);
    assign outstanding = req && !imem_ready_i;
    assign rsp_halt    = is_halt(imem_rdata_i[WIDTH-1 -: 4], HALT_OPCODE);

    assign buf_load  = resp_run && stall_i && !redirect_i;
    assign buf_drain = buf_valid && !stall_i && !redirect_i;

    fetch_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .drain      (buf_drain),
        .clear      (redirect_i),
        .load_instr (imem_rdata_i),
        .load_pc    (pc_plus2),
        .valid      (buf_valid),
        .instr      (buf_instr),
        .pc         (buf_pc)
    );

    // NOTE: every output gets a default before any branch so the block stays
    // purely combinational instead of inferring latches.
    always_comb begin
        imem_req_o   = req;
        imem_addr_o  = pc;
        ifid_wen_o   = !rst && (!stall_i || redirect_i);
        halted_o     = !rst && (state == ST_HALTED);
        ifid_pc_o    = pc_plus2;
        ifid_instr_o = NOP_INSTR;
        if (rst) begin
            ifid_pc_o = '0;
        end else if (!redirect_i) begin
            // The buffered entry is older than anything memory returns now.
            if (buf_valid) begin
                ifid_pc_o    = buf_pc;
                ifid_instr_o = buf_instr;
            end else if (resp_run) begin
                ifid_instr_o = imem_rdata_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            pc    <= RESET_PC;
            tgt   <= RESET_PC;
        end else if (redirect_i) begin
            if (outstanding) begin
                // Memory requests cannot be aborted: keep the address stable
                // and park the target until the stale response returns.
                tgt   <= redirect_pc_i;
                state <= ST_KILL;
            end else begin
                // Idle or same-cycle response: the response is dropped.
                pc    <= redirect_pc_i;
                state <= ST_RUN;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    if (resp_run) begin
                        // A HALT is still delivered/buffered; pc stays on it.
                        if (rsp_halt) begin
                            state <= ST_HALTED;
                        end else begin
                            pc <= pc_plus2;
                        end
                    end
                end
                ST_KILL: begin
                    if (resp_kill) begin
                        pc    <= tgt;
                        state <= ST_RUN;
                    end
                end
                default: ;  // ST_HALTED: only rst or redirect leaves
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [15:0] NOP = 16'h0000;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        ifid_wen;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_instr;
    logic        halted;

    // second instance: reset PC at the top of the address space
    logic        w_stall = 1'b0;
    logic        w_redirect = 1'b0;
    logic [15:0] w_redirect_pc = 16'h0000;
    logic        w_req;
    logic [15:0] w_addr;
    logic        w_ready;
    logic [15:0] w_rdata;
    logic        w_wen;
    logic [15:0] w_pc;
    logic [15:0] w_instr;
    logic        w_halted;

    // memory model state
    int          mem_lat = 0;
    int          wait_cnt;
    logic        halt_en = 1'b0;
    logic [15:0] halt_addr = 16'h0000;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ready_i  (imem_ready),
        .imem_rdata_i  (imem_rdata),
        .ifid_wen_o    (ifid_wen),
        .ifid_pc_o     (ifid_pc),
        .ifid_instr_o  (ifid_instr),
        .halted_o      (halted)
    );

    fetch_unit #(
        .RESET_PC (16'hFFFE)
    ) u_wrap (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (w_stall),
        .redirect_i    (w_redirect),
        .redirect_pc_i (w_redirect_pc),
        .imem_req_o    (w_req),
        .imem_addr_o   (w_addr),
        .imem_ready_i  (w_ready),
        .imem_rdata_i  (w_rdata),
        .ifid_wen_o    (w_wen),
        .ifid_pc_o     (w_pc),
        .ifid_instr_o  (w_instr),
        .halted_o      (w_halted)
    );

    assign w_ready = w_req;
    assign w_rdata = {4'h1, w_addr[11:0]};

    // Memory: ready once the request has waited mem_lat cycles; words are
    // address-based with an optional HALT planted at halt_addr.
    always_comb begin
        imem_ready = 1'b0;
        imem_rdata = 16'h0000;
        if (imem_req && (wait_cnt >= mem_lat)) begin
            imem_ready = 1'b1;
            imem_rdata = (halt_en && imem_addr == halt_addr) ? 16'hF000
                                                             : {4'h1, imem_addr[11:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !imem_req || imem_ready) wait_cnt <= 0;
        else                                wait_cnt <= wait_cnt + 1;
    end

    task automatic do_reset(input int lat);
        rst      = 1'b1;
        stall    = 1'b0;
        redirect = 1'b0;
        halt_en  = 1'b0;
        mem_lat  = lat;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (imem_req !== 1'b0) $display("FAIL reset_req c%0d got=%b exp=0", c, imem_req);
            else n_pass++;
            n_checks++;
            if (ifid_wen !== 1'b0) $display("FAIL reset_wen c%0d got=%b exp=0", c, ifid_wen);
            else n_pass++;
            n_checks++;
            if (halted !== 1'b0) $display("FAIL reset_halted c%0d got=%b exp=0", c, halted);
            else n_pass++;
            n_checks++;
            if (ifid_pc !== 16'h0000) $display("FAIL reset_pc c%0d got=%h exp=0000", c, ifid_pc);
            else n_pass++;
            n_checks++;
            if (ifid_instr !== NOP) $display("FAIL reset_instr c%0d got=%h exp=%h", c, ifid_instr, NOP);
            else n_pass++;
            @(posedge clk);
        end
        #1 rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_stream();
        exp_t e;
        for (int i = 0; i < 4; i++) exp_q.push_back('{pc: 16'(2*i + 2), instr: 16'h1000 + 16'(2*i)});
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 16'(2*c))
                $display("FAIL stream_addr c%0d got req=%b addr=%h exp req=1 addr=%h", c, imem_req, imem_addr, 16'(2*c));
            else n_pass++;
            n_checks++;
            if (ifid_wen !== 1'b1) $display("FAIL stream_wen c%0d got=%b exp=1", c, ifid_wen);
            else n_pass++;
            if (ifid_wen === 1'b1 && ifid_instr !== NOP) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL stream_extra c%0d got pc=%h instr=%h exp none", c, ifid_pc, ifid_instr);
                else begin
                    e = exp_q.pop_front();
                    if (ifid_pc !== e.pc || ifid_instr !== e.instr)
                        $display("FAIL stream_deliv c%0d got pc=%h instr=%h exp pc=%h instr=%h", c, ifid_pc, ifid_instr, e.pc, e.instr);
                    else n_pass++;
                end
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL stream_missing got=%0d left exp=0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_stall_buffer();
        exp_t e;
        do_reset(1);
        exp_q.push_back('{pc: 16'h0002, instr: 16'h1000});
        exp_q.push_back('{pc: 16'h0004, instr: 16'h1002});
        exp_q.push_back('{pc: 16'h0006, instr: 16'h1004});
        for (int c = 0; c < 9; c++) begin
            stall = (c >= 4 && c <= 6);
            @(negedge clk);
            if (c >= 4 && c <= 6) begin
                n_checks++;
                if (ifid_wen !== 1'b0) $display("FAIL stall_wen c%0d got=%b exp=0", c, ifid_wen);
                else n_pass++;
            end
            if (c == 6 || c == 7) begin
                n_checks++;
                if (imem_req !== 1'b0) $display("FAIL stall_req_drop c%0d got=%b exp=0", c, imem_req);
                else n_pass++;
            end
            if (c == 8) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== 16'h0006)
                    $display("FAIL stall_next_req got req=%b addr=%h exp req=1 addr=0006", imem_req, imem_addr);
                else n_pass++;
            end
            if (ifid_wen === 1'b1 && ifid_instr !== NOP) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL stall_extra c%0d got pc=%h instr=%h exp none", c, ifid_pc, ifid_instr);
                else begin
                    e = exp_q.pop_front();
                    if (ifid_pc !== e.pc || ifid_instr !== e.instr)
                        $display("FAIL stall_deliv c%0d got pc=%h instr=%h exp pc=%h instr=%h", c, ifid_pc, ifid_instr, e.pc, e.instr);
                    else n_pass++;
                end
            end
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL stall_missing got=%0d left exp=0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_redirect_wait();
        exp_t e;
        do_reset(0);
        for (int i = 0; i < 4; i++) exp_q.push_back('{pc: 16'(2*i + 2), instr: 16'h1000 + 16'(2*i)});
        exp_q.push_back('{pc: 16'h0042, instr: 16'h1040});
        redirect_pc = 16'h0040;
        for (int c = 0; c < 9; c++) begin
            redirect = (c == 4);
            if (c == 4) mem_lat = 3;
            if (c == 8) mem_lat = 0;
            @(negedge clk);
            if (c == 4) begin
                n_checks++;
                if (ifid_wen !== 1'b1 || ifid_instr !== NOP)
                    $display("FAIL redir_flush got wen=%b instr=%h exp wen=1 instr=%h", ifid_wen, ifid_instr, NOP);
                else n_pass++;
            end
            if (c >= 5 && c <= 7) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== 16'h0008)
                    $display("FAIL redir_hold_addr c%0d got req=%b addr=%h exp req=1 addr=0008", c, imem_req, imem_addr);
                else n_pass++;
            end
            if (c == 7) begin
                n_checks++;
                if (ifid_instr !== NOP) $display("FAIL redir_discard got=%h exp=%h", ifid_instr, NOP);
                else n_pass++;
            end
            if (c == 8) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== 16'h0040)
                    $display("FAIL redir_target got req=%b addr=%h exp req=1 addr=0040", imem_req, imem_addr);
                else n_pass++;
            end
            if (ifid_wen === 1'b1 && ifid_instr !== NOP) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL redir_extra c%0d got pc=%h instr=%h exp none", c, ifid_pc, ifid_instr);
                else begin
                    e = exp_q.pop_front();
                    if (ifid_pc !== e.pc || ifid_instr !== e.instr)
                        $display("FAIL redir_deliv c%0d got pc=%h instr=%h exp pc=%h instr=%h", c, ifid_pc, ifid_instr, e.pc, e.instr);
                    else n_pass++;
                end
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL redir_missing got=%0d left exp=0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_redirect_stall();
        exp_t e;
        do_reset(0);
        exp_q.push_back('{pc: 16'h0022, instr: 16'h1020});
        redirect_pc = 16'h0020;
        for (int c = 0; c < 3; c++) begin
            stall    = (c <= 1);
            redirect = (c == 1);
            @(negedge clk);
            if (c == 0) begin
                n_checks++;
                if (ifid_wen !== 1'b0) $display("FAIL rs_stall_wen got=%b exp=0", ifid_wen);
                else n_pass++;
            end
            if (c == 1) begin
                n_checks++;
                if (ifid_wen !== 1'b1 || ifid_instr !== NOP || imem_req !== 1'b0)
                    $display("FAIL rs_flush got wen=%b instr=%h req=%b exp wen=1 instr=%h req=0", ifid_wen, ifid_instr, imem_req, NOP);
                else n_pass++;
            end
            if (c == 2) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== 16'h0020)
                    $display("FAIL rs_target got req=%b addr=%h exp req=1 addr=0020", imem_req, imem_addr);
                else n_pass++;
            end
            if (ifid_wen === 1'b1 && ifid_instr !== NOP) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL rs_extra c%0d got pc=%h instr=%h exp none", c, ifid_pc, ifid_instr);
                else begin
                    e = exp_q.pop_front();
                    if (ifid_pc !== e.pc || ifid_instr !== e.instr)
                        $display("FAIL rs_deliv c%0d got pc=%h instr=%h exp pc=%h instr=%h", c, ifid_pc, ifid_instr, e.pc, e.instr);
                    else n_pass++;
                end
            end
            @(posedge clk);
            #1;
        end
        stall    = 1'b0;
        redirect = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL rs_missing got=%0d left exp=0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_halt();
        exp_t e;
        do_reset(0);
        halt_en   = 1'b1;
        halt_addr = 16'h000A;
        for (int i = 0; i < 5; i++) exp_q.push_back('{pc: 16'(2*i + 2), instr: 16'h1000 + 16'(2*i)});
        exp_q.push_back('{pc: 16'h000C, instr: 16'hF000});
        exp_q.push_back('{pc: 16'h0002, instr: 16'h1000});
        redirect_pc = 16'h0000;
        for (int c = 0; c < 10; c++) begin
            redirect = (c == 8);
            @(negedge clk);
            if (c == 6 || c == 7) begin
                n_checks++;
                if (halted !== 1'b1 || imem_req !== 1'b0)
                    $display("FAIL halt_frozen c%0d got halted=%b req=%b exp halted=1 req=0", c, halted, imem_req);
                else n_pass++;
            end
            if (c == 8) begin
                n_checks++;
                if (ifid_wen !== 1'b1 || ifid_instr !== NOP)
                    $display("FAIL halt_redir got wen=%b instr=%h exp wen=1 instr=%h", ifid_wen, ifid_instr, NOP);
                else n_pass++;
            end
            if (c == 9) begin
                n_checks++;
                if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0000)
                    $display("FAIL halt_resume got halted=%b req=%b addr=%h exp halted=0 req=1 addr=0000", halted, imem_req, imem_addr);
                else n_pass++;
            end
            if (ifid_wen === 1'b1 && ifid_instr !== NOP) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL halt_extra c%0d got pc=%h instr=%h exp none", c, ifid_pc, ifid_instr);
                else begin
                    e = exp_q.pop_front();
                    if (ifid_pc !== e.pc || ifid_instr !== e.instr)
                        $display("FAIL halt_deliv c%0d got pc=%h instr=%h exp pc=%h instr=%h", c, ifid_pc, ifid_instr, e.pc, e.instr);
                    else n_pass++;
                end
            end
            @(posedge clk);
            #1;
        end
        redirect = 1'b0;
        halt_en  = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL halt_missing got=%0d left exp=0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_wrap();
        exp_t e;
        do_reset(0);
        exp_q.push_back('{pc: 16'h0000, instr: 16'h1FFE});
        exp_q.push_back('{pc: 16'h0002, instr: 16'h1000});
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (w_req !== 1'b1 || w_addr !== ((c == 0) ? 16'hFFFE : 16'h0000))
                $display("FAIL wrap_addr c%0d got req=%b addr=%h exp req=1 addr=%h", c, w_req, w_addr, (c == 0) ? 16'hFFFE : 16'h0000);
            else n_pass++;
            if (w_wen === 1'b1 && w_instr !== NOP) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL wrap_extra c%0d got pc=%h instr=%h exp none", c, w_pc, w_instr);
                else begin
                    e = exp_q.pop_front();
                    if (w_pc !== e.pc || w_instr !== e.instr)
                        $display("FAIL wrap_deliv c%0d got pc=%h instr=%h exp pc=%h instr=%h", c, w_pc, w_instr, e.pc, e.instr);
                    else n_pass++;
                end
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL wrap_missing got=%0d left exp=0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_buffer();
        test_redirect_wait();
        test_redirect_stall();
        test_halt();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
